// File: rtl/j1708_rx_msg_ctrl.sv
// J1708 receive message controller: frames UART bytes into idle-bounded messages, checks checksum/MID/length.
// Latency: accepted byte reaches msg_byte one cycle after its strobe; msg_done follows the closing idle by two cycles.
// Backpressure: none upstream; a full FIFO on a data byte aborts the message and the FIFO rewinds via msg_abort.
module j1708_rx_msg_ctrl #(
   parameter int MAX_LEN     = 21,
   parameter int MIN_LEN     = 2,
   parameter int LEN_W       = 8,
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic             i_line_idle,
   input  logic [7:0]       i_rx_byte,
   input  logic             i_rx_byte_valid,
   input  logic             i_tx_active,
   input  logic             i_fifo_full,
   input  logic             i_mid_filter_en,
   input  logic [7:0]       i_mid_filter,
   output logic [7:0]       o_msg_byte,
   output logic             o_msg_byte_valid,
   output logic             o_msg_abort,
   output logic             o_msg_done,
   output logic [LEN_W-1:0] o_msg_length,
   output logic             o_chk_err,
   output logic [7:0]       o_drop_count
);

   localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LP_MIN = LEN_W'(MIN_LEN);

   typedef enum logic [2:0] {
      STATE_RESET        = 3'd0,
      STATE_IDLE         = 3'd1,
      STATE_GET_MID      = 3'd2,
      STATE_GET_BYTE     = 3'd3,
      STATE_DISCARD      = 3'd4,
      STATE_WAIT_TX_IDLE = 3'd5,
      STATE_DONE         = 3'd6
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic [7:0]       r_sum;
   logic [7:0]       w_sum_nxt;
   logic             w_fwd;
   logic             w_abort;
   logic             w_mid_rej;
   logic             w_close;
   logic             w_commit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= STATE_RESET;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a byte arriving together with idle is taken first, then the message closes
   always_comb begin
      w_state_nxt = r_state;
      if (!i_enable) begin
         w_state_nxt = STATE_RESET;
      end else begin
         case (r_state)
            STATE_RESET: begin
               if (i_line_idle) w_state_nxt = STATE_IDLE;
            end
            STATE_IDLE: begin
               if (!i_line_idle) w_state_nxt = i_tx_active ? STATE_WAIT_TX_IDLE : STATE_GET_MID;
            end
            STATE_WAIT_TX_IDLE: begin
               if (i_line_idle) w_state_nxt = STATE_IDLE;
            end
            STATE_GET_MID: begin
               if (w_mid_rej)    w_state_nxt = i_line_idle ? STATE_IDLE : STATE_DISCARD;
               else if (w_abort) w_state_nxt = STATE_IDLE;
               else if (w_close) w_state_nxt = STATE_DONE;
               else if (w_fwd)   w_state_nxt = STATE_GET_BYTE;
               else if (i_line_idle) w_state_nxt = STATE_IDLE;
            end
            STATE_GET_BYTE: begin
               if (w_abort)      w_state_nxt = i_line_idle ? STATE_IDLE : STATE_DISCARD;
               else if (w_close) w_state_nxt = STATE_DONE;
            end
            STATE_DISCARD: begin
               if (i_line_idle) w_state_nxt = STATE_IDLE;
            end
            STATE_DONE: begin
               w_state_nxt = STATE_IDLE;
            end
            default: begin
               w_state_nxt = STATE_RESET;
            end
         endcase
      end
   end

   // Output decisions: forward/abort/commit plus next count and running sum
   always_comb begin
      w_fwd     = 1'b0;
      w_abort   = 1'b0;
      w_mid_rej = 1'b0;
      w_close   = 1'b0;
      w_commit  = 1'b0;
      w_cnt_nxt = r_cnt;
      w_sum_nxt = r_sum;
      if (!i_enable) begin
         // Only states holding forwarded-but-uncommitted bytes need the FIFO rewound
         w_abort = (r_state == STATE_GET_BYTE) || (r_state == STATE_DONE);
      end else begin
         if (r_state == STATE_GET_MID && i_rx_byte_valid) begin
            if (i_mid_filter_en && (i_rx_byte != i_mid_filter)) begin
               w_mid_rej = 1'b1;
            end else begin
               w_fwd     = 1'b1;
               w_cnt_nxt = LEN_W'(1);
               w_sum_nxt = i_rx_byte;
            end
         end else if (r_state == STATE_GET_BYTE && i_rx_byte_valid) begin
            // Length cap is checked before the increment so the counter never wraps
            if ((r_cnt == LP_MAX) || i_fifo_full) begin
               w_abort = 1'b1;
            end else begin
               w_fwd     = 1'b1;
               w_cnt_nxt = r_cnt + LEN_W'(1);
               w_sum_nxt = r_sum + i_rx_byte;
            end
         end
         w_close = i_line_idle &&
                   (((r_state == STATE_GET_MID) && w_fwd) ||
                    ((r_state == STATE_GET_BYTE) && !w_abort));
         if (w_close && (w_cnt_nxt < LP_MIN)) begin
            w_abort = 1'b1;
         end
         w_commit = (r_state == STATE_DONE);
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt            <= '0;
         r_sum            <= '0;
         o_msg_byte       <= '0;
         o_msg_byte_valid <= 1'b0;
         o_msg_abort      <= 1'b0;
         o_msg_done       <= 1'b0;
         o_msg_length     <= '0;
         o_chk_err        <= 1'b0;
         o_drop_count     <= '0;
      end else begin
         r_cnt            <= w_cnt_nxt;
         r_sum            <= w_sum_nxt;
         o_msg_byte_valid <= w_fwd;
         o_msg_abort      <= w_abort;
         o_msg_done       <= w_commit;
         if (w_fwd) begin
            o_msg_byte <= i_rx_byte;
         end
         if (w_abort) begin
            if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
         end else if (!i_enable) begin
            o_drop_count <= '0;
         end
         if (!i_enable && !w_abort) begin
            o_msg_length <= '0;
            o_chk_err    <= 1'b0;
         end else if (w_commit) begin
            o_msg_length <= r_cnt;
            o_chk_err    <= CHECKSUM_EN && (r_sum != 8'h00);
         end
      end
   end

endmodule

// File: tb/tb_j1708_rx_msg_ctrl.sv
// Testbench for j1708_rx_msg_ctrl: vector table, hand sequences and random messages vs a message-level model.
// Latency: compares forwarding and abort cycles against the strobe/idle cycles it drove.
// Backpressure: exercises fifo_full on data bytes and the length cap.
module tb_j1708_rx_msg_ctrl;

   localparam int MAX_LEN = 21;
   localparam int MIN_LEN = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_enable, i_line_idle, i_rx_byte_valid, i_tx_active, i_fifo_full, i_mid_filter_en;
   logic [7:0] i_rx_byte, i_mid_filter;
   logic [7:0] o_msg_byte, o_drop_count, o_msg_length;
   logic       o_msg_byte_valid, o_msg_abort, o_msg_done, o_chk_err;

   j1708_rx_msg_ctrl #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .LEN_W(8), .CHECKSUM_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_line_idle(i_line_idle),
      .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid), .i_tx_active(i_tx_active),
      .i_fifo_full(i_fifo_full), .i_mid_filter_en(i_mid_filter_en), .i_mid_filter(i_mid_filter),
      .o_msg_byte(o_msg_byte), .o_msg_byte_valid(o_msg_byte_valid), .o_msg_abort(o_msg_abort),
      .o_msg_done(o_msg_done), .o_msg_length(o_msg_length), .o_chk_err(o_chk_err),
      .o_drop_count(o_drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // Observed traffic for the current message
   logic [7:0] fwd_q[$];
   int         fwd_cyc_q[$];
   int         strobe_q[$];
   int         abort_n, done_n, abort_cyc, done_cyc, idle_exp;
   int         overlap_n = 0;

   // Expected persistent outputs
   int exp_drop = 0;
   int exp_len  = 0;
   int exp_chk  = 0;

   // Monitor samples outputs on the falling edge
   always @(negedge clk) begin
      if (o_msg_byte_valid) begin
         fwd_q.push_back(o_msg_byte);
         fwd_cyc_q.push_back(cyc);
         if (o_msg_done) overlap_n++;
      end
      if (o_msg_abort) begin abort_n++; abort_cyc = cyc; end
      if (o_msg_done)  begin done_n++;  done_cyc  = cyc; end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input string what, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s.%s got %0d expected %0d", tag, what, act, exp);
   endtask

   // Drive one message: line busy, bytes with random gaps, then idle (optionally with the last byte)
   task automatic run_msg(input logic [7:0] mb[$], input int full_at, input bit txa,
                          input bit close_last, input int maxgap);
      fwd_q.delete(); fwd_cyc_q.delete(); strobe_q.delete();
      abort_n = 0; done_n = 0; abort_cyc = -1; done_cyc = -1;
      i_tx_active = txa;
      i_line_idle = 1'b0;
      tick(); tick();
      for (int i = 0; i < mb.size(); i++) begin
         i_rx_byte       = mb[i];
         i_rx_byte_valid = 1'b1;
         i_fifo_full     = (i == full_at);
         strobe_q.push_back(cyc + 1);
         if (close_last && i == mb.size() - 1) begin
            i_line_idle = 1'b1;
            idle_exp    = cyc + 1;
         end
         tick();
         i_rx_byte_valid = 1'b0;
         i_fifo_full     = 1'b0;
         if (!(close_last && i == mb.size() - 1)) repeat ($urandom_range(maxgap, 0)) tick();
      end
      if (!close_last) begin
         i_line_idle = 1'b1;
         idle_exp    = cyc + 1;
      end
      repeat (6) tick();
      i_tx_active = 1'b0;
   endtask

   // Message-level reference: what the FIFO side should see for a message
   task automatic model(input logic [7:0] mb[$], input int full_at, input bit txa, input bit fen,
                        input logic [7:0] flt, output int efwd, output bit eab, output bit edn);
      int cut;
      int s;
      efwd = 0; eab = 1'b0; edn = 1'b0; cut = -1; s = 0;
      if (!(txa || (fen && mb[0] != flt))) begin
         for (int i = 1; i < mb.size(); i++)
            if (cut < 0 && (i >= MAX_LEN || i == full_at)) cut = i;
         if (cut >= 0) begin
            efwd = cut;
            eab  = 1'b1;
         end else begin
            efwd = mb.size();
            if (mb.size() < MIN_LEN) eab = 1'b1;
            else begin
               edn = 1'b1;
               foreach (mb[i]) s += int'(mb[i]);
               exp_len = mb.size();
               exp_chk = ((s % 256) != 0) ? 1 : 0;
            end
         end
      end
      if (eab && exp_drop < 255) exp_drop++;
   endtask

   task automatic compare_obs(input string tag, input logic [7:0] mb[$], input int efwd,
                              input bit eab, input bit edn);
      int bad_dat = 0;
      int bad_lat = 0;
      chk(tag, "fwd_count", fwd_q.size(), efwd);
      for (int i = 0; i < fwd_q.size() && i < efwd; i++) begin
         if (fwd_q[i] !== mb[i]) bad_dat++;
         if (fwd_cyc_q[i] != strobe_q[i]) bad_lat++;
      end
      chk(tag, "fwd_data_errs", bad_dat, 0);
      chk(tag, "fwd_latency_errs", bad_lat, 0);
      chk(tag, "abort_pulses", abort_n, eab ? 1 : 0);
      if (eab) chk(tag, "abort_cycle", abort_cyc, (efwd < mb.size()) ? strobe_q[efwd] : idle_exp);
      chk(tag, "done_pulses", done_n, edn ? 1 : 0);
      if (edn && fwd_cyc_q.size() > 0)
         chk(tag, "done_after_last_byte", (done_cyc > fwd_cyc_q[fwd_cyc_q.size() - 1]) ? 1 : 0, 1);
      chk(tag, "msg_length", int'(o_msg_length), exp_len);
      chk(tag, "chk_err", int'(o_chk_err), exp_chk);
      chk(tag, "drop_count", int'(o_drop_count), exp_drop);
   endtask

   typedef struct {
      logic [7:0] b0, b1, b2;
      int         n;
      bit         fen;
      logic [7:0] flt;
      bit         txa;
      int         fwd;
      bit         ab;
      bit         dn;
      int         len;
      int         chk;
      int         drop;
   } vec_t;

   initial begin
      vec_t       vt[9];
      logic [7:0] mb[$];
      int         efwd;
      bit         eab, edn;
      logic [7:0] flt;
      bit         fen, txa, cl;
      int         n, full_at, s;

      vt[0] = '{8'h80, 8'h01, 8'h7F,  3, 1'b0, 8'h00, 1'b0,  3, 1'b0, 1'b1,  3, 0, 0};
      vt[1] = '{8'h80, 8'h01, 8'h00,  3, 1'b0, 8'h00, 1'b0,  3, 1'b0, 1'b1,  3, 1, 0};
      vt[2] = '{8'h80, 8'h00, 8'h00,  1, 1'b0, 8'h00, 1'b0,  1, 1'b1, 1'b0,  3, 1, 1};
      vt[3] = '{8'h80, 8'h01, 8'h02, 22, 1'b0, 8'h00, 1'b0, 21, 1'b1, 1'b0,  3, 1, 2};
      vt[4] = '{8'h80, 8'h80, 8'h00,  2, 1'b0, 8'h00, 1'b0,  2, 1'b0, 1'b1,  2, 0, 2};
      vt[5] = '{8'h81, 8'h01, 8'h7E,  3, 1'b1, 8'h80, 1'b0,  0, 1'b0, 1'b0,  2, 0, 2};
      vt[6] = '{8'h80, 8'h01, 8'h7F,  3, 1'b1, 8'h80, 1'b0,  3, 1'b0, 1'b1,  3, 0, 2};
      vt[7] = '{8'h80, 8'h01, 8'h7F,  3, 1'b0, 8'h00, 1'b1,  0, 1'b0, 1'b0,  3, 0, 2};
      vt[8] = '{8'h80, 8'h01, 8'h02, 21, 1'b0, 8'h00, 1'b0, 21, 1'b0, 1'b1, 21, 1, 2};

      rst = 1'b1; i_enable = 1'b1; i_line_idle = 1'b1; i_rx_byte = 8'h00; i_rx_byte_valid = 1'b0;
      i_tx_active = 1'b0; i_fifo_full = 1'b0; i_mid_filter_en = 1'b0; i_mid_filter = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset", "msg_byte_valid", int'(o_msg_byte_valid), 0);
      chk("reset", "msg_abort", int'(o_msg_abort), 0);
      chk("reset", "msg_done", int'(o_msg_done), 0);
      chk("reset", "msg_length", int'(o_msg_length), 0);
      chk("reset", "chk_err", int'(o_chk_err), 0);
      chk("reset", "drop_count", int'(o_drop_count), 0);
      chk("reset", "msg_byte", int'(o_msg_byte), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) tick();

      // Vector table
      for (int r = 0; r < 9; r++) begin
         mb.delete();
         for (int i = 0; i < vt[r].n; i++)
            mb.push_back(i == 0 ? vt[r].b0 : i == 1 ? vt[r].b1 : i == 2 ? vt[r].b2 : 8'(i));
         i_mid_filter_en = vt[r].fen;
         i_mid_filter    = vt[r].flt;
         run_msg(mb, -1, vt[r].txa, 1'b0, 1);
         exp_len = vt[r].len; exp_chk = vt[r].chk; exp_drop = vt[r].drop;
         compare_obs($sformatf("vec%0d", r), mb, vt[r].fwd, vt[r].ab, vt[r].dn);
      end
      i_mid_filter_en = 1'b0;

      // Last byte and idle arrive in the same cycle: the byte belongs to the message
      mb = '{8'h80, 8'h01, 8'h7F};
      run_msg(mb, -1, 1'b0, 1'b1, 0);
      model(mb, -1, 1'b0, 1'b0, 8'h00, efwd, eab, edn);
      compare_obs("same_cycle_idle", mb, efwd, eab, edn);

      // Enable dropped after two forwarded bytes
      i_line_idle = 1'b0; tick(); tick();
      i_rx_byte = 8'h80; i_rx_byte_valid = 1'b1; tick(); i_rx_byte_valid = 1'b0; tick();
      i_rx_byte = 8'h01; i_rx_byte_valid = 1'b1; tick(); i_rx_byte_valid = 1'b0; tick();
      i_enable = 1'b0;
      tick();
      chk("enable_drop", "msg_abort", int'(o_msg_abort), 1);
      chk("enable_drop", "drop_count", int'(o_drop_count), exp_drop + 1);
      chk("enable_drop", "msg_byte_valid", int'(o_msg_byte_valid), 0);
      exp_drop++;
      i_enable = 1'b1;
      tick();
      chk("enable_drop", "abort_single_pulse", int'(o_msg_abort), 0);
      fwd_q.delete();
      i_rx_byte = 8'h55; i_rx_byte_valid = 1'b1; tick(); i_rx_byte_valid = 1'b0; tick(); tick();
      chk("enable_drop", "busy_bus_not_rearmed", fwd_q.size(), 0);
      i_line_idle = 1'b1; repeat (4) tick();
      mb = '{8'h80, 8'h80};
      run_msg(mb, -1, 1'b0, 1'b0, 1);
      model(mb, -1, 1'b0, 1'b0, 8'h00, efwd, eab, edn);
      compare_obs("rearm_after_idle", mb, efwd, eab, edn);

      // Drop counter saturation
      mb = '{8'h80};
      for (int k = 0; k < 256; k++) begin
         run_msg(mb, -1, 1'b0, 1'b0, 0);
         model(mb, -1, 1'b0, 1'b0, 8'h00, efwd, eab, edn);
      end
      chk("saturate", "drop_count", int'(o_drop_count), 255);

      // Enable low while idle clears the status outputs
      i_enable = 1'b0; tick(); tick();
      chk("disable_clear", "drop_count", int'(o_drop_count), 0);
      chk("disable_clear", "msg_length", int'(o_msg_length), 0);
      chk("disable_clear", "chk_err", int'(o_chk_err), 0);
      i_enable = 1'b1; repeat (3) tick();
      exp_drop = 0; exp_len = 0; exp_chk = 0;

      // Random messages against the reference model
      for (int m = 0; m < 40; m++) begin
         n = $urandom_range(24, 1);
         mb.delete();
         s = 0;
         for (int i = 0; i < n; i++) begin
            mb.push_back(8'($urandom));
            s += int'(mb[i]);
         end
         if (($urandom % 2) == 0 && n > 1) mb[n - 1] = 8'(256 - ((s - int'(mb[n - 1])) % 256));
         fen = (($urandom % 4) == 0);
         flt = (($urandom % 2) == 0) ? mb[0] : 8'($urandom);
         txa = (($urandom % 8) == 0);
         full_at = ((($urandom % 5) == 0) && n > 1) ? int'($urandom_range(n - 1, 1)) : -1;
         cl  = (($urandom % 4) == 0);
         i_mid_filter_en = fen;
         i_mid_filter    = flt;
         run_msg(mb, full_at, txa, cl, 2);
         model(mb, full_at, txa, fen, flt, efwd, eab, edn);
         compare_obs($sformatf("rand%0d", m), mb, efwd, eab, edn);
      end

      chk("global", "done_with_byte_valid", overlap_n, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/j1708_rx_msg_ctrl.md
Name: j1708_rx_msg_ctrl

Overview:
Parametrised J1708 receive message controller. Sits between the J1708 byte UART and the RX FIFO/register block. It frames bytes into messages bounded by bus-idle, forwards bytes to the FIFO, and verifies the J1708 checksum. It also applies an optional MID filter, enforces minimum and maximum lengths, and signals the FIFO to rewind on any discarded partial message.

Parameters:
MAX_LEN, 21, maximum accepted message length in bytes, MID and checksum included (2..255)
MIN_LEN, 2, minimum legal length; shorter messages are dropped (1..MAX_LEN)
LEN_W, 8, width of msg_length (must hold MAX_LEN)
CHECKSUM_EN, 1, 1 = compute checksum status; 0 = chk_err always 0

Ports:
clk  in  1  system clock
rst  in  1  reset
enable  in  1  block enable; low = synchronous clear
line_idle  in  1  J1708 bus-idle indication
rx_byte  in  8  received byte
rx_byte_valid  in  1  1-cycle strobe, rx_byte valid
tx_active  in  1  local transmitter owns current message
fifo_full  in  1  RX FIFO cannot accept a byte
mid_filter_en  in  1  enable MID filter
mid_filter  in  8  MID to accept when filter enabled
msg_byte  out  8  byte to FIFO
msg_byte_valid  out  1  FIFO write strobe
msg_abort  out  1  1-cycle pulse: FIFO rewinds to last committed message
msg_done  out  1  1-cycle pulse: message committed
msg_length  out  LEN_W  length of last committed message
chk_err  out  1  checksum status of last committed message
drop_count  out  8  saturating count of aborted messages

Behaviour:
- Reset: rst is asynchronous and active-high. All outputs and the state reset to 0 / STATE_RESET.
- States: RESET, IDLE, GET_MID, GET_BYTE, DISCARD, WAIT_TX_IDLE, DONE.
- RESET -> IDLE when line_idle=1. Entering IDLE only from a known idle bus prevents mid-message wakeup.
- IDLE -> stays while line_idle=1. On line_idle=0: WAIT_TX_IDLE if tx_active=1, else GET_MID.
- WAIT_TX_IDLE -> IDLE on line_idle=1. Own echoed bytes are never forwarded.
- GET_MID, on rx_byte_valid:
  - if mid_filter_en=1 and rx_byte!=mid_filter -> DISCARD; nothing forwarded, no abort.
  - else forward the byte, cnt=1, sum=rx_byte -> GET_BYTE.
  - if line_idle returns before any byte -> IDLE.
- GET_BYTE, on rx_byte_valid:
  - if cnt==MAX_LEN or fifo_full=1 -> abort, DISCARD.
  - else forward the byte, cnt+1, sum+=rx_byte (mod 256).
- GET_BYTE, on line_idle=1:
  - if cnt<MIN_LEN -> abort, IDLE.
  - else -> DONE.
- If line_idle and rx_byte_valid occur in the same cycle, the byte is processed first and the message then closes including it.
- DONE (one cycle) -> IDLE. Pulses msg_done and loads msg_length=cnt and chk_err=(CHECKSUM_EN && sum!=0).
- DISCARD -> IDLE on line_idle=1. All bytes are ignored.
- Forwarding latency: msg_byte/msg_byte_valid registered exactly 1 cycle after the accepted rx_byte_valid.
- msg_done asserts in the cycle after the last msg_byte_valid, and never in the same cycle as msg_byte_valid.
- Abort timing: msg_abort pulses 1 cycle after the abort decision. drop_count increments with it and saturates at 255.
- Abort is issued only when at least one byte has been forwarded for the current message. A filtered MID never aborts.
- msg_length and chk_err hold until the next DONE.
- cnt width is LEN_W and never wraps, because the MAX_LEN check precedes the increment.
- enable=0 mid-message: next cycle state=RESET, msg_byte_valid=0, msg_done=0. msg_abort pulses once if bytes were forwarded, and drop_count increments.
- enable=0 otherwise: msg_length, chk_err and drop_count are cleared.
- rst mid-message: immediate clear, no abort pulse. The FIFO is reset by the same rst.

Test Plan:
- 1. Bus idle, then bytes 0x80,0x01,0x7F, then idle. Expect 3 msg_byte_valid 1 cycle after each strobe; msg_done then msg_length=3, chk_err=0.
- 2. Bytes 0x80,0x01,0x00, then idle. Expect msg_done, msg_length=3, chk_err=1.
- 3. Single byte 0x80, then idle. Expect 1 msg_byte_valid, msg_abort pulse, no msg_done, drop_count=1.
- 4. MAX_LEN=21: send 22 bytes. Expect 21 forwarded, msg_abort 1 cycle after the 22nd strobe, no msg_done. A following legal 2-byte message is committed with msg_length=2.
- 5. mid_filter_en=1, mid_filter=0x80: message with MID 0x81 gives no outputs at all. Message with MID 0x80 is committed normally.
- 6. tx_active=1 at idle->busy transition: no forwarding, state returns to IDLE at line_idle.
- 7. enable dropped after 2 bytes: msg_abort pulse, then RESET. The block re-arms only after line_idle.
